// File: rtl/uart_sys_pkg.sv
// -----------------------------------------------------------------------------
// uart_sys_pkg
//   Shared definitions for the UART command path.
//   This package provides:
//     - the command opcodes that the first byte of a frame may carry,
//     - the RF addresses that hold ALU operands A and B,
//     - the command-controller state encoding,
//     - a helper function that maps an opcode byte to the controller's first
//       capture state. Any byte that is not a command maps to IDLE.
// -----------------------------------------------------------------------------
package uart_sys_pkg;

   // Frame opcodes (first byte received while idle)
   localparam logic [7:0] CMD_RF_WR   = 8'hAA;  // RF write : ADDR, DATA
   localparam logic [7:0] CMD_RF_RD   = 8'hBB;  // RF read  : ADDR
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // ALU      : A, B, FUN
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // ALU      : FUN

   // RF locations the ALU reads its operands from
   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;

   // Command controller state encoding
   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      WR_ADDR  = 4'd1,
      WR_DATA  = 4'd2,
      RD_ADDR  = 4'd3,
      RD_WAIT  = 4'd4,
      OP_A     = 4'd5,
      OP_B     = 4'd6,
      ALU_FN   = 4'd7,
      ALU_WAIT = 4'd8,
      TX_B0    = 4'd9,
      TX_B1    = 4'd10
   } state_t;

   // First state of a frame for a given opcode byte.
   // Unknown opcodes return IDLE, so stray bytes are dropped.
   function automatic state_t cmd_decode(input logic [7:0] b);
      case (b)
         CMD_RF_WR:   return WR_ADDR;
         CMD_RF_RD:   return RD_ADDR;
         CMD_ALU_OP:  return OP_A;
         CMD_ALU_NOP: return ALU_FN;
         default:     return IDLE;
      endcase
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//   This is the command controller that sits behind the UART receiver.
//   It parses byte frames and sequences register-file writes and reads and
//   ALU operations. It pushes each response into the TX FIFO one byte at a time.
//   Every output is registered, and every output clears on RST.
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   RX_P_DATA / RX_D_VLD     received byte and its 1-cycle strobe
//   RF_Address               RF address for the write or read strobe
//   RF_WrEn / RF_WrData      RF write strobe (1 cycle) and write data
//   RF_RdEn                  RF read strobe (1 cycle)
//   RF_RdData / _VLD         RF read data and its valid strobe
//   ALU_EN / ALU_FUN         ALU start strobe and function code
//   CLK_GATE_EN              ALU clock enable, high in ALU_FN and ALU_WAIT
//   ALU_OUT / ALU_OUT_VLD    ALU result and its valid strobe
//   TX_P_DATA / TX_D_VLD     byte pushed into the TX FIFO and its push strobe
//   FIFO_FULL                TX FIFO full; a push waits while this is high
//
// ALU_OUT_WIDTH must be 2*DATA_WIDTH, because the result is sent as two bytes.
// -----------------------------------------------------------------------------
module uart_cmd_ctrl
   import uart_sys_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_OUT_WIDTH = 16,
   parameter int FUN_WIDTH     = 4,
   parameter int WAIT_TIMEOUT  = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
   input  logic                     RX_D_VLD,
   output logic [ADDR_WIDTH-1:0]    RF_Address,
   output logic                     RF_WrEn,
   output logic [DATA_WIDTH-1:0]    RF_WrData,
   output logic                     RF_RdEn,
   input  logic [DATA_WIDTH-1:0]    RF_RdData,
   input  logic                     RF_RdData_VLD,
   output logic                     ALU_EN,
   output logic [FUN_WIDTH-1:0]     ALU_FUN,
   output logic                     CLK_GATE_EN,
   input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
   input  logic                     ALU_OUT_VLD,
   output logic [DATA_WIDTH-1:0]    TX_P_DATA,
   output logic                     TX_D_VLD,
   input  logic                     FIFO_FULL
);

   localparam int                CNT_W    = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

   state_t                    state;
   state_t                    cmd_state;
   logic [CNT_W-1:0]          wait_cnt;
   logic                      alu_started;
   logic                      rd_done;
   logic                      alu_done;
   logic                      wait_expired;

   // Data holding registers. These carry no reset, because control qualifies
   // every use of them.
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [ALU_OUT_WIDTH-1:0]  res_q;

   assign cmd_state    = cmd_decode(RX_P_DATA[7:0]);
   assign rd_done      = (state == RD_WAIT) && RF_RdData_VLD;
   // A valid seen before ALU_EN has been issued belongs to an older operation.
   assign alu_done     = (state == ALU_WAIT) && alu_started && ALU_OUT_VLD;
   assign wait_expired = (wait_cnt == CNT_LAST);

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         alu_started <= 1'b0;
         RF_Address  <= '0;
         RF_WrEn     <= 1'b0;
         RF_WrData   <= '0;
         RF_RdEn     <= 1'b0;
         ALU_EN      <= 1'b0;
         ALU_FUN     <= '0;
         CLK_GATE_EN <= 1'b0;
         TX_P_DATA   <= '0;
         TX_D_VLD    <= 1'b0;
      end else begin
         // Each strobe lasts one cycle unless a state asserts it again.
         RF_WrEn  <= 1'b0;
         RF_RdEn  <= 1'b0;
         ALU_EN   <= 1'b0;
         TX_D_VLD <= 1'b0;

         case (state)
            IDLE: begin
               if (RX_D_VLD) begin
                  state <= cmd_state;
                  if (cmd_state == ALU_FN)
                     CLK_GATE_EN <= 1'b1;
               end
            end

            WR_ADDR: begin
               if (RX_D_VLD)
                  state <= WR_DATA;
            end

            WR_DATA: begin
               if (RX_D_VLD) begin
                  RF_WrEn    <= 1'b1;
                  RF_Address <= addr_q;
                  RF_WrData  <= RX_P_DATA;
                  state      <= IDLE;
               end
            end

            RD_ADDR: begin
               if (RX_D_VLD) begin
                  RF_RdEn    <= 1'b1;
                  RF_Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                  wait_cnt   <= '0;
                  state      <= RD_WAIT;
               end
            end

            RD_WAIT: begin
               // The response is one byte, so it goes straight to the
               // upper-byte push state.
               if (rd_done)
                  state <= TX_B1;
               else if (wait_expired)
                  state <= IDLE;
               else
                  wait_cnt <= wait_cnt + CNT_W'(1);
            end

            OP_A: begin
               if (RX_D_VLD) begin
                  RF_WrEn    <= 1'b1;
                  RF_Address <= ADDR_WIDTH'(OPA_ADDR);
                  RF_WrData  <= RX_P_DATA;
                  state      <= OP_B;
               end
            end

            OP_B: begin
               if (RX_D_VLD) begin
                  RF_WrEn     <= 1'b1;
                  RF_Address  <= ADDR_WIDTH'(OPB_ADDR);
                  RF_WrData   <= RX_P_DATA;
                  CLK_GATE_EN <= 1'b1;
                  state       <= ALU_FN;
               end
            end

            ALU_FN: begin
               if (RX_D_VLD) begin
                  ALU_FUN     <= RX_P_DATA[FUN_WIDTH-1:0];
                  alu_started <= 1'b0;
                  wait_cnt    <= '0;
                  state       <= ALU_WAIT;
               end
            end

            ALU_WAIT: begin
               // ALU_EN goes out one cycle after ALU_FUN updates, so the
               // function code is stable when the ALU starts.
               if (!alu_started) begin
                  ALU_EN      <= 1'b1;
                  alu_started <= 1'b1;
               end
               if (alu_done) begin
                  CLK_GATE_EN <= 1'b0;
                  state       <= TX_B0;
               end else if (wait_expired) begin
                  CLK_GATE_EN <= 1'b0;
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            TX_B0: begin
               if (!FIFO_FULL) begin
                  TX_D_VLD  <= 1'b1;
                  TX_P_DATA <= res_q[DATA_WIDTH-1:0];
                  state     <= TX_B1;
               end
            end

            TX_B1: begin
               if (!FIFO_FULL) begin
                  TX_D_VLD  <= 1'b1;
                  TX_P_DATA <= res_q[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Frame data capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if ((state == WR_ADDR) && RX_D_VLD)
         addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
      // RF read data shares the upper-byte slot with the ALU result, so both
      // responses leave through TX_B1.
      if (rd_done)
         res_q[ALU_OUT_WIDTH-1 -: DATA_WIDTH] <= RF_RdData;
      if (alu_done)
         res_q <= ALU_OUT;
   end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//   Bench for uart_cmd_ctrl. It plays the UART RX side, the register file,
//   the ALU and the TX FIFO. Each command frame is scored against a
//   frame-level model: the expected RF writes, RF reads, ALU starts and TX
//   bytes, all derived from the command bytes and a shadow RF.
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

   logic        CLK;
   logic        RST;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic [3:0]  RF_Address;
   logic        RF_WrEn;
   logic [7:0]  RF_WrData;
   logic        RF_RdEn;
   logic [7:0]  RF_RdData;
   logic        RF_RdData_VLD;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic        CLK_GATE_EN;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_VLD;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        FIFO_FULL;

   uart_cmd_ctrl dut (
      .CLK           (CLK),
      .RST           (RST),
      .RX_P_DATA     (RX_P_DATA),
      .RX_D_VLD      (RX_D_VLD),
      .RF_Address    (RF_Address),
      .RF_WrEn       (RF_WrEn),
      .RF_WrData     (RF_WrData),
      .RF_RdEn       (RF_RdEn),
      .RF_RdData     (RF_RdData),
      .RF_RdData_VLD (RF_RdData_VLD),
      .ALU_EN        (ALU_EN),
      .ALU_FUN       (ALU_FUN),
      .CLK_GATE_EN   (CLK_GATE_EN),
      .ALU_OUT       (ALU_OUT),
      .ALU_OUT_VLD   (ALU_OUT_VLD),
      .TX_P_DATA     (TX_P_DATA),
      .TX_D_VLD      (TX_D_VLD),
      .FIFO_FULL     (FIFO_FULL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk;
   int n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Environment ALU: the operation the attached ALU performs on RF[0], RF[1]
   function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
      case (f)
         4'd0:    return 16'(a) + 16'(b);
         4'd1:    return 16'(a) - 16'(b);
         4'd2:    return 16'(a) * 16'(b);
         4'd3:    return {8'h00, a & b};
         default: return {a ^ b, 4'h0, f};
      endcase
   endfunction

   // ---------------- observed event logs (written only by the monitor) -------
   logic [11:0] wr_q[$];
   logic [3:0]  rd_q[$];
   logic [3:0]  alu_q[$];
   logic [7:0]  tx_q[$];
   bit   [7:0]  rf_mem[16];   // the register file the DUT actually drives
   int          full_viol;
   int          gate_viol;
   logic        full_at_edge;

   always @(posedge CLK) full_at_edge = FIFO_FULL;

   always @(negedge CLK) begin
      if (!RST) begin
         if (RF_WrEn) begin
            wr_q.push_back({RF_Address, RF_WrData});
            rf_mem[RF_Address] = RF_WrData;
         end
         if (RF_RdEn) rd_q.push_back(RF_Address);
         if (ALU_EN) begin
            alu_q.push_back(ALU_FUN);
            if (!CLK_GATE_EN) gate_viol++;
         end
         if (TX_D_VLD) begin
            tx_q.push_back(TX_P_DATA);
            if (full_at_edge) full_viol++;
         end
      end
   end

   // ---------------- RF / ALU / FIFO responder -------------------------------
   int rsp_lat;
   int rsp_hold;
   bit rsp_on;

   initial begin
      logic       rd;
      logic [3:0] a;
      RF_RdData     = '0;
      RF_RdData_VLD = 1'b0;
      ALU_OUT       = '0;
      ALU_OUT_VLD   = 1'b0;
      FIFO_FULL     = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RST && rsp_on && (RF_RdEn || ALU_EN)) begin
            rd = RF_RdEn;
            a  = RF_Address;
            repeat (rsp_lat - 1) @(negedge CLK);
            if (rd) begin
               RF_RdData     = rf_mem[a];
               RF_RdData_VLD = 1'b1;
            end else begin
               ALU_OUT     = alu_calc(rf_mem[0], rf_mem[1], ALU_FUN);
               ALU_OUT_VLD = 1'b1;
            end
            FIFO_FULL = (rsp_hold > 0);
            @(negedge CLK);
            RF_RdData_VLD = 1'b0;
            ALU_OUT_VLD   = 1'b0;
            if (rsp_hold > 1) repeat (rsp_hold - 1) @(negedge CLK);
            FIFO_FULL = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------------------------------
   bit [7:0] ref_mem[16];   // RF contents implied by the commands sent so far

   task automatic send(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge CLK);
      @(negedge CLK);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'($urandom);
   endtask

   function automatic int gp();
      return int'($urandom_range(0, 2));
   endfunction

   task automatic score(input logic [11:0] ew[$], input logic [3:0] er[$],
                        input logic [3:0] ea[$], input logic [7:0] et[$],
                        input int wb, input int rb, input int ab, input int tb);
      check("rf_wr_count", wr_q.size() - wb, ew.size());
      for (int i = 0; i < ew.size(); i++)
         if (wb + i < wr_q.size()) check("rf_wr_addr_data", wr_q[wb+i], ew[i]);
      check("rf_rd_count", rd_q.size() - rb, er.size());
      for (int i = 0; i < er.size(); i++)
         if (rb + i < rd_q.size()) check("rf_rd_addr", rd_q[rb+i], er[i]);
      check("alu_en_count", alu_q.size() - ab, ea.size());
      for (int i = 0; i < ea.size(); i++)
         if (ab + i < alu_q.size()) check("alu_fun", alu_q[ab+i], ea[i]);
      check("tx_push_count", tx_q.size() - tb, et.size());
      for (int i = 0; i < et.size(); i++)
         if (tb + i < tx_q.size()) check("tx_byte", tx_q[tb+i], et[i]);
      check("push_while_full", full_viol, 0);
      check("alu_en_gate_off", gate_viol, 0);
      check("gate_idle", CLK_GATE_EN, 1'b0);
   endtask

   // kind: 0 RF write(b1 addr, b2 data), 1 RF read(b1 addr),
   //       2 ALU with operands(b1 A, b2 B, b3 FUN), 3 ALU fun only(b1 FUN),
   //       4 lone non-command byte(b1)
   task automatic txn(input int kind, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input int lat, input int hold,
                      input bit resp, input bit junk);
      logic [11:0] ew[$];
      logic [3:0]  er[$];
      logic [3:0]  ea[$];
      logic [7:0]  et[$];
      logic [15:0] r;
      int wb, rb, ab, tb;
      wb = wr_q.size(); rb = rd_q.size(); ab = alu_q.size(); tb = tx_q.size();
      rsp_lat = lat; rsp_hold = hold; rsp_on = resp;
      case (kind)
         0: begin
            ew.push_back({b1[3:0], b2});
            ref_mem[b1[3:0]] = b2;
            send(8'hAA, gp()); send(b1, gp()); send(b2, gp());
         end
         1: begin
            er.push_back(b1[3:0]);
            if (resp) et.push_back(ref_mem[b1[3:0]]);
            send(8'hBB, gp()); send(b1, gp());
            if (junk) send(8'hAA, 0);
         end
         2: begin
            ew.push_back({4'd0, b1});
            ew.push_back({4'd1, b2});
            ref_mem[0] = b1;
            ref_mem[1] = b2;
            ea.push_back(b3[3:0]);
            r = alu_calc(ref_mem[0], ref_mem[1], b3[3:0]);
            if (resp) begin et.push_back(r[7:0]); et.push_back(r[15:8]); end
            send(8'hCC, gp()); send(b1, gp()); send(b2, gp()); send(b3, gp());
            if (junk) send(8'hAA, 0);
         end
         3: begin
            ea.push_back(b1[3:0]);
            r = alu_calc(ref_mem[0], ref_mem[1], b1[3:0]);
            if (resp) begin et.push_back(r[7:0]); et.push_back(r[15:8]); end
            send(8'hDD, gp()); send(b1, gp());
            if (junk) send(8'hAA, 0);
         end
         default: send(b1, gp());
      endcase
      repeat (34) @(negedge CLK);
      score(ew, er, ea, et, wb, rb, ab, tb);
   endtask

   // A read with no reply must time out after exactly 16 wait cycles.
   // A byte that lands on the timeout cycle is dropped; one cycle later
   // it starts a new frame.
   task automatic timeout_probe(input bit late);
      logic [11:0] ew[$];
      logic [3:0]  er[$];
      logic [3:0]  ea[$];
      logic [7:0]  et[$];
      int wb, rb, ab, tb;
      wb = wr_q.size(); rb = rd_q.size(); ab = alu_q.size(); tb = tx_q.size();
      rsp_on = 1'b0;
      er.push_back(4'd3);
      send(8'hBB, 1); send(8'h03, 0);
      send(8'hAA, late ? 15 : 14);
      send(8'h02, 0); send(8'h77, 0);
      if (late) begin
         ew.push_back({4'd2, 8'h77});
         ref_mem[2] = 8'h77;
      end
      repeat (20) @(negedge CLK);
      score(ew, er, ea, et, wb, rb, ab, tb);
   endtask

   task automatic check_outputs_zero(input string tag);
      check(tag, {RF_Address, RF_WrEn, RF_WrData, RF_RdEn, ALU_EN, ALU_FUN,
                  CLK_GATE_EN, TX_P_DATA, TX_D_VLD}, 32'd0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int kind, hold, wb;
      logic [7:0] b1, b2, b3;
      n_chk = 0;
      n_err = 0;
      RST = 1'b1;
      RX_D_VLD = 1'b0;
      RX_P_DATA = '0;
      rsp_on = 1'b0; rsp_lat = 1; rsp_hold = 0;
      repeat (3) @(negedge CLK);
      check_outputs_zero("reset_outputs");
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      // Directed frames
      txn(0, 8'h05, 8'h3C, 8'h00, 1, 0, 1, 0);   // RF write 5 <= 3C
      txn(1, 8'h07, 8'h00, 8'h00, 2, 0, 1, 0);   // RF read 7
      txn(1, 8'h05, 8'h00, 8'h00, 2, 0, 1, 1);   // read back 3C, AA during wait
      txn(2, 8'h10, 8'h20, 8'h00, 3, 0, 1, 0);   // 10+20 -> 30, 00
      txn(2, 8'h12, 8'h34, 8'h02, 3, 5, 1, 0);   // FIFO full 5 cycles, 0x03A8
      txn(4, 8'h7E, 8'h00, 8'h00, 1, 0, 1, 0);   // stray byte in idle
      txn(1, 8'h03, 8'h00, 8'h00, 1, 0, 0, 0);   // read without reply
      txn(3, 8'h01, 8'h00, 8'h00, 14, 0, 1, 0);  // latest ALU reply in budget
      txn(1, 8'h05, 8'h00, 8'h00, 14, 6, 1, 0);  // latest RF reply, full held
      timeout_probe(1'b0);
      timeout_probe(1'b1);

      // Reset inside an ALU wait, then inside a write frame
      wb = wr_q.size();
      rsp_on = 1'b0;
      send(8'hDD, 0); send(8'h07, 0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check_outputs_zero("reset_in_alu_wait");
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      send(8'hAA, 0); send(8'h05, 0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      check_outputs_zero("reset_mid_frame");
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      check("reset_no_partial_write", wr_q.size() - wb, 0);
      txn(0, 8'h01, 8'hFF, 8'h00, 1, 0, 1, 0);
      txn(1, 8'h01, 8'h00, 8'h00, 4, 0, 1, 0);

      // Randomized frames
      for (int n = 0; n < 70; n++) begin
         kind = int'($urandom_range(0, 4));
         b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
         if (kind == 4)
            while (b1 == 8'hAA || b1 == 8'hBB || b1 == 8'hCC || b1 == 8'hDD)
               b1 = 8'($urandom);
         hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
         txn(kind, b1, b2, b3, int'($urandom_range(1, 14)), hold,
             $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
